// File: rtl/ws2812b_frame_controller.sv
// WS2812B impostor receive-path sequencer.
// Waits for line idle, captures this device's own 24-bit GRB pixel (MSB first),
// then asserts forward_en so every later bit of the frame passes through to DOUT.
// The pixel is published on the idle that ends the frame. Also owns the idle
// detector threshold register.
module ws2812b_frame_controller #(
    parameter logic [31:0] IDLE_DEFAULT = 32'd4000,
    parameter logic [31:0] MIN_IDLE     = 32'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_write,
    input  logic [31:0] cfg_idle_ticks,
    output logic [31:0] idle_threshold_ticks,
    input  logic        idle,
    input  logic        bit_valid,
    input  logic        bit_value,
    output logic [23:0] color_out,
    output logic        color_valid,
    output logic        forward_en,
    output logic        short_frame,
    output logic [15:0] frame_count,
    output logic [15:0] fwd_bits
);

    localparam logic [2:0] S_SYNC    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_FORWARD = 3'd3;
    localparam logic [2:0] S_LATCH   = 3'd4;

    // Count value held while the 24th pixel bit arrives.
    localparam logic [4:0] LAST_BIT_CNT = 5'd23;

    // Programmed thresholds below the floor would let normal inter-bit gaps
    // look like a frame end, so they are raised to MIN_IDLE.
    function automatic logic [31:0] clamp_threshold(input logic [31:0] ticks);
        clamp_threshold = (ticks < MIN_IDLE) ? MIN_IDLE : ticks;
    endfunction

    // Forwarded-bit counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        sat_inc16 = (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    logic [2:0]  state_q,       state_d;
    logic [23:0] shift_q,       shift_d;
    logic [4:0]  count_q,       count_d;
    logic [23:0] color_q,       color_d;
    logic        color_valid_q, color_valid_d;
    logic        fwd_en_q,      fwd_en_d;
    logic        short_q,       short_d;
    logic [15:0] frame_cnt_q,   frame_cnt_d;
    logic [15:0] fwd_bits_q,    fwd_bits_d;
    logic [31:0] thresh_q,      thresh_d;

    // Threshold register: independent of the frame FSM, updates in any state.
    always_comb begin
        thresh_d = thresh_q;
        if (cfg_write) begin
            thresh_d = clamp_threshold(cfg_idle_ticks);
        end
    end

    // Frame FSM next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        count_d       = count_q;
        color_d       = color_q;
        color_valid_d = 1'b0;
        short_d       = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        fwd_bits_d    = fwd_bits_q;

        if (!enable) begin
            // Abandon any frame in progress; published pixel and counters stay.
            state_d = S_SYNC;
            count_d = 5'd0;
        end else begin
            case (state_q)
                S_SYNC: begin
                    // Bits are ignored until the line has been idle once, so
                    // capture never starts in the middle of a frame.
                    if (idle) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (bit_valid) begin
                        shift_d = {23'd0, bit_value};
                        count_d = 5'd1;
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Idle has priority: a bit arriving with it is dropped.
                    if (idle) begin
                        short_d = 1'b1;
                        shift_d = 24'd0;
                        count_d = 5'd0;
                        state_d = S_ARMED;
                    end else if (bit_valid) begin
                        shift_d = {shift_q[22:0], bit_value};
                        count_d = count_q + 5'd1;
                        if (count_q == LAST_BIT_CNT) begin
                            fwd_bits_d = 16'd0;
                            state_d    = S_FORWARD;
                        end
                    end
                end
                S_FORWARD: begin
                    // Pixel is published on the edge into LATCH, so color_valid
                    // is high during the LATCH cycle, one cycle after idle.
                    if (idle) begin
                        color_d       = shift_q;
                        color_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                        state_d       = S_LATCH;
                    end else if (bit_valid) begin
                        fwd_bits_d = sat_inc16(fwd_bits_q);
                    end
                end
                S_LATCH: begin
                    count_d = 5'd0;
                    state_d = S_ARMED;
                end
                default: begin
                    state_d = S_SYNC;
                end
            endcase
        end

        // Registered pass-through gate: follows the state being entered.
        fwd_en_d = (state_d == S_FORWARD);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_SYNC;
            shift_q       <= 24'd0;
            count_q       <= 5'd0;
            color_q       <= 24'd0;
            color_valid_q <= 1'b0;
            fwd_en_q      <= 1'b0;
            short_q       <= 1'b0;
            frame_cnt_q   <= 16'd0;
            fwd_bits_q    <= 16'd0;
            thresh_q      <= IDLE_DEFAULT;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            fwd_en_q      <= fwd_en_d;
            short_q       <= short_d;
            frame_cnt_q   <= frame_cnt_d;
            fwd_bits_q    <= fwd_bits_d;
            thresh_q      <= thresh_d;
        end
    end

    assign idle_threshold_ticks = thresh_q;
    assign color_out            = color_q;
    assign color_valid          = color_valid_q;
    assign forward_en           = fwd_en_q;
    assign short_frame          = short_q;
    assign frame_count          = frame_cnt_q;
    assign fwd_bits             = fwd_bits_q;

endmodule

// File: tb/tb_ws2812b_frame_controller.sv
// Directed, table-driven bench for ws2812b_frame_controller.
module tb_ws2812b_frame_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cfg_write;
    logic [31:0] cfg_idle_ticks;
    logic [31:0] idle_threshold_ticks;
    logic        idle;
    logic        bit_valid;
    logic        bit_value;
    logic [23:0] color_out;
    logic        color_valid;
    logic        forward_en;
    logic        short_frame;
    logic [15:0] frame_count;
    logic [15:0] fwd_bits;

    int n_cmp = 0;
    int n_err = 0;
    int cv_cnt = 0;
    int sf_cnt = 0;
    int both_cnt = 0;
    logic [15:0] exp_fc;
    logic [23:0] exp_color;

    typedef struct {
        logic [23:0] px;
        int          extra;
        logic [15:0] exp_fwd;
    } frame_vec_t;

    typedef struct {
        logic [31:0] cfg_in;
        logic [31:0] exp_thr;
    } cfg_vec_t;

    frame_vec_t fvec[4];
    cfg_vec_t   cvec[7];

    ws2812b_frame_controller dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .cfg_write            (cfg_write),
        .cfg_idle_ticks       (cfg_idle_ticks),
        .idle_threshold_ticks (idle_threshold_ticks),
        .idle                 (idle),
        .bit_valid            (bit_valid),
        .bit_value            (bit_value),
        .color_out            (color_out),
        .color_valid          (color_valid),
        .forward_en           (forward_en),
        .short_frame          (short_frame),
        .frame_count          (frame_count),
        .fwd_bits             (fwd_bits)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (color_valid) cv_cnt++;
            if (short_frame) sf_cnt++;
            if (color_valid && short_frame) both_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_value = b;
        tick();
        bit_valid = 1'b0;
        bit_value = 1'b0;
        tick();
    endtask

    task automatic idle_pulse();
        idle = 1'b1;
        tick();
        idle = 1'b0;
    endtask

    // Full frame from ARMED: 24 pixel bits, extra forwarded bits, idle.
    task automatic run_frame(input logic [23:0] px, input int extra, input logic [15:0] exp_fwd);
        int cv0;
        int sf0;
        cv0 = cv_cnt;
        sf0 = sf_cnt;
        for (int i = 23; i >= 0; i--) begin
            if (i == 0) chk("fwd_en_before_bit24", {31'd0, forward_en}, 32'd0);
            send_bit(px[i]);
        end
        chk("fwd_en_after_bit24", {31'd0, forward_en}, 32'd1);
        for (int i = 0; i < extra; i++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        chk("fwd_en_held", {31'd0, forward_en}, 32'd1);
        idle_pulse();
        chk("fwd_en_drop_on_idle", {31'd0, forward_en}, 32'd0);
        tick();
        tick();
        exp_fc    = exp_fc + 16'd1;
        exp_color = px;
        chk("color_out", {8'd0, color_out}, {8'd0, px});
        chk("fwd_bits", {16'd0, fwd_bits}, {16'd0, exp_fwd});
        chk("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
        chk("color_valid_pulses", cv_cnt - cv0, 32'd1);
        chk("no_short_frame", sf_cnt - sf0, 32'd0);
    endtask

    initial begin
        int cv0;
        int sf0;

        fvec[0] = '{px: 24'hA5C3F0, extra: 0,  exp_fwd: 16'd0};
        fvec[1] = '{px: 24'h112233, extra: 48, exp_fwd: 16'd48};
        fvec[2] = '{px: 24'h00FF00, extra: 0,  exp_fwd: 16'd0};
        fvec[3] = '{px: 24'h800001, extra: 5,  exp_fwd: 16'd5};

        cvec[0] = '{cfg_in: 32'd10,         exp_thr: 32'd64};
        cvec[1] = '{cfg_in: 32'd0,          exp_thr: 32'd64};
        cvec[2] = '{cfg_in: 32'd63,         exp_thr: 32'd64};
        cvec[3] = '{cfg_in: 32'd64,         exp_thr: 32'd64};
        cvec[4] = '{cfg_in: 32'd65,         exp_thr: 32'd65};
        cvec[5] = '{cfg_in: 32'hFFFF_FFFF,  exp_thr: 32'hFFFF_FFFF};
        cvec[6] = '{cfg_in: 32'd5000,       exp_thr: 32'd5000};

        rst_n          = 1'b0;
        enable         = 1'b1;
        cfg_write      = 1'b0;
        cfg_idle_ticks = 32'd0;
        idle           = 1'b0;
        bit_valid      = 1'b0;
        bit_value      = 1'b0;
        exp_fc         = 16'd0;
        exp_color      = 24'd0;
        tick();
        tick();

        // Reset values.
        chk("rst_color_out", {8'd0, color_out}, 32'd0);
        chk("rst_color_valid", {31'd0, color_valid}, 32'd0);
        chk("rst_forward_en", {31'd0, forward_en}, 32'd0);
        chk("rst_short_frame", {31'd0, short_frame}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_fwd_bits", {16'd0, fwd_bits}, 32'd0);
        chk("rst_threshold", idle_threshold_ticks, 32'd4000);
        rst_n = 1'b1;
        tick();

        // SYNC: bits before the first idle are ignored.
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        chk("sync_no_color_valid", cv_cnt, 32'd0);
        chk("sync_no_short", sf_cnt, 32'd0);
        chk("sync_fwd_en", {31'd0, forward_en}, 32'd0);
        idle_pulse();
        tick();

        // Frame table.
        for (int i = 0; i < 4; i++) begin
            run_frame(fvec[i].px, fvec[i].extra, fvec[i].exp_fwd);
        end

        // Short frame: 12 bits then idle.
        cv0 = cv_cnt;
        sf0 = sf_cnt;
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        idle_pulse();
        tick();
        chk("short_pulse", sf_cnt - sf0, 32'd1);
        chk("short_no_cv", cv_cnt - cv0, 32'd0);
        chk("short_color_kept", {8'd0, color_out}, {8'd0, exp_color});
        chk("short_fc_kept", {16'd0, frame_count}, {16'd0, exp_fc});
        run_frame(24'h5A5A5A, 2, 16'd2);

        // enable dropped mid-capture (after bit 15).
        cv0 = cv_cnt;
        sf0 = sf_cnt;
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        idle_pulse();
        tick();
        chk("en_capture_no_cv", cv_cnt - cv0, 32'd0);
        chk("en_capture_no_short", sf_cnt - sf0, 32'd0);
        chk("en_capture_color_kept", {8'd0, color_out}, {8'd0, exp_color});
        run_frame(24'h123456, 1, 16'd1);

        // enable dropped while forwarding.
        cv0 = cv_cnt;
        for (int i = 23; i >= 0; i--) send_bit(1'b1);
        send_bit(1'b0);
        chk("en_fwd_before", {31'd0, forward_en}, 32'd1);
        enable = 1'b0;
        tick();
        chk("en_fwd_dropped", {31'd0, forward_en}, 32'd0);
        enable = 1'b1;
        idle_pulse();
        tick();
        chk("en_fwd_no_cv", cv_cnt - cv0, 32'd0);
        chk("en_fwd_color_kept", {8'd0, color_out}, {8'd0, exp_color});
        chk("en_fwd_fc_kept", {16'd0, frame_count}, {16'd0, exp_fc});

        // Threshold configuration table.
        for (int i = 0; i < 7; i++) begin
            cfg_write      = 1'b1;
            cfg_idle_ticks = cvec[i].cfg_in;
            tick();
            cfg_write      = 1'b0;
            cfg_idle_ticks = 32'd0;
            chk("cfg_threshold", idle_threshold_ticks, cvec[i].exp_thr);
            tick();
            chk("cfg_threshold_hold", idle_threshold_ticks, cvec[i].exp_thr);
        end

        // Asynchronous reset mid-frame, checked before any clock edge.
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_threshold", idle_threshold_ticks, 32'd4000);
        chk("async_color_out", {8'd0, color_out}, 32'd0);
        chk("async_frame_count", {16'd0, frame_count}, 32'd0);
        exp_fc    = 16'd0;
        exp_color = 24'd0;
        tick();
        rst_n = 1'b1;
        tick();
        idle_pulse();
        tick();

        // Frame counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        tick();
        exp_fc = 16'hFFFF;
        chk("preload_frame_count", {16'd0, frame_count}, 32'h0000_FFFF);
        run_frame(24'hC0FFEE, 0, 16'd0);
        chk("wrap_frame_count", {16'd0, frame_count}, 32'd0);

        chk("cv_short_exclusive", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
